wb_port_arbiter: RTL and testbench

//   Shares the single register-file write port between two write-back requesters:
//     req0 = main datapath (ALU/load result; dest already chosen rt/rd by the 5-bit dest mux)
//     req1 = long-latency unit (mult/div)

---
 rtl/wb_port_arbiter_pkg.sv | 17 +
 rtl/wb_port_arbiter_rr_arbiter2.sv | 63 ++++++
 rtl/wb_port_arbiter.sv | 108 ++++++++++
 tb/tb_wb_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter.
// Holds the register-file geometry, the zero-register address and the
// write-source identifiers.
package wb_port_arbiter_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [WB_ADDR_W-1:0] WB_REG_ZERO = 5'd0;

  // Identity of the requester that produced a register-file write
  typedef enum logic {
    WB_SRC_MAIN = 1'b0,
    WB_SRC_MDU  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-request round-robin arbiter.
// Grants are combinational from req, en and the priority flop. The priority
// flop points at the requester that wins the next tie and moves to the
// other requester after every grant.
module rr_arbiter2
  import wb_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic prio_r;

  // Pick at most one winner; ties are resolved by the priority pointer
  always_comb begin
    gnt    = 2'b00;
    gnt_id = WB_SRC_MAIN;
    if (en) begin
      case (req)
        2'b01: begin
          gnt    = 2'b01;
          gnt_id = WB_SRC_MAIN;
        end
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = WB_SRC_MDU;
        end
        2'b11: begin
          if (prio_r) begin
            gnt    = 2'b10;
            gnt_id = WB_SRC_MDU;
          end else begin
            gnt    = 2'b01;
            gnt_id = WB_SRC_MAIN;
          end
        end
        default: begin
          gnt    = 2'b00;
          gnt_id = WB_SRC_MAIN;
        end
      endcase
    end else begin
      gnt    = 2'b00;
      gnt_id = WB_SRC_MAIN;
    end
  end

  // Priority pointer: favour the loser of the last grant, hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (gnt != 2'b00) begin
      prio_r <= ~gnt_id;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the main
// datapath (req0) and the long-latency mult/div unit (req1).
// The round-robin winner is registered onto rf_we/rf_waddr/rf_wdata/rf_wsrc
// one cycle after the handshake. Accepted writes to register 0 are consumed
// without raising rf_we when ZERO_SUPPRESS is set.
// Optional feature macro: WB_FWD_EN adds write-to-read forwarding ports
// that expose the in-flight registered write.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W        = WB_DATA_W,
  parameter int ADDR_W        = WB_ADDR_W,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_raddr_a,
  input  logic [ADDR_W-1:0] fwd_raddr_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wsrc
);

  logic              en_s;
  logic [1:0]        gnt_s;
  logic              gnt_id_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_zero_s;

  assign en_s = ~wb_stall & ~rst;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (en_s),
    .req    ({req1_valid, req0_valid}),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign req0_ready = gnt_s[0];
  assign req1_ready = gnt_s[1];
  assign xfer_s     = gnt_s[0] | gnt_s[1];

  // Route the winning requester's address and data toward the output stage
  always_comb begin
    sel_addr_s = req0_addr;
    sel_data_s = req0_data;
    if (gnt_id_s == WB_SRC_MDU) begin
      sel_addr_s = req1_addr;
      sel_data_s = req1_data;
    end else begin
      sel_addr_s = req0_addr;
      sel_data_s = req0_data;
    end
  end

  assign sel_zero_s = ZERO_SUPPRESS && (sel_addr_s == {ADDR_W{1'b0}});

  // Write-back stage register: capture the winner, pulse rf_we for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      rf_wsrc  <= WB_SRC_MAIN;
    end else if (xfer_s) begin
      rf_we    <= ~sel_zero_s;
      rf_waddr <= sel_addr_s;
      rf_wdata <= sel_data_s;
      rf_wsrc  <= gnt_id_s;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= rf_waddr;
      rf_wdata <= rf_wdata;
      rf_wsrc  <= rf_wsrc;
    end
  end

`ifdef WB_FWD_EN
  // Forward the in-flight write to readers of the same non-zero register
  always_comb begin
    fwd_hit_a  = rf_we && (rf_waddr == fwd_raddr_a) && (fwd_raddr_a != {ADDR_W{1'b0}});
    fwd_hit_b  = rf_we && (rf_waddr == fwd_raddr_b) && (fwd_raddr_b != {ADDR_W{1'b0}});
    fwd_data_a = rf_wdata;
    fwd_data_b = rf_wdata;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a directed vector table for the
// reset / single / zero-register / contention / stall / reset-after-transfer
// cases, then randomized traffic checked against a behavioural model.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_stall;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wsrc;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_raddr_a;
  logic [4:0]  fwd_raddr_b;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_a;
  logic [31:0] fwd_data_b;
`endif

  wb_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wb_stall   (wb_stall),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
`ifdef WB_FWD_EN
    .fwd_raddr_a(fwd_raddr_a),
    .fwd_raddr_b(fwd_raddr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
`endif
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_wsrc    (rf_wsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          r0;     // expected req0_ready this cycle
    bit          r1;     // expected req1_ready this cycle
    bit          chk;    // compare registered outputs this cycle
    bit          we;     // expected registered outputs this cycle
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          ws;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // behavioural reference: priority holder and expected write-port contents
  int          m_prio;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_ws;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(bit r, bit s, bit v0, logic [4:0] a0, logic [31:0] d0,
                              bit v1, logic [4:0] a1, logic [31:0] d1,
                              bit r0, bit r1, bit c, bit we, logic [4:0] wa,
                              logic [31:0] wd, bit ws);
    vec_t v;
    v.rst = r; v.stall = s; v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
    v.chk = c; v.we = we; v.wa = wa; v.wd = wd; v.ws = ws;
    return v;
  endfunction

  // Drive one cycle, compare, advance the model, then step past the clock edge.
  task automatic apply(input vec_t v, input bit use_tbl, input string tag);
    int w;
    rst = v.rst; wb_stall = v.stall;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    #2;
    if (v.rst || v.stall) w = -1;
    else if (v.v0 && v.v1) w = m_prio;
    else if (v.v0) w = 0;
    else if (v.v1) w = 1;
    else w = -1;
    if (use_tbl) begin
      chk({tag, " ready0"}, {31'd0, req0_ready}, {31'd0, v.r0});
      chk({tag, " ready1"}, {31'd0, req1_ready}, {31'd0, v.r1});
      if (v.chk) begin
        chk({tag, " rf_we"},    {31'd0, rf_we},    {31'd0, v.we});
        chk({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, v.wa});
        chk({tag, " rf_wdata"}, rf_wdata,          v.wd);
        chk({tag, " rf_wsrc"},  {31'd0, rf_wsrc},  {31'd0, v.ws});
      end
    end else begin
      chk({tag, " ready0"}, {31'd0, req0_ready}, {31'd0, (w == 0)});
      chk({tag, " ready1"}, {31'd0, req1_ready}, {31'd0, (w == 1)});
      chk({tag, " rf_we"},  {31'd0, rf_we},      {31'd0, m_we});
      if (m_we) begin
        chk({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, m_wa});
        chk({tag, " rf_wdata"}, rf_wdata,          m_wd);
        chk({tag, " rf_wsrc"},  {31'd0, rf_wsrc},  {31'd0, m_ws});
      end
    end
    if (v.rst) begin
      m_prio = 0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_ws = 1'b0;
    end else if (w >= 0) begin
      m_wa   = (w == 1) ? v.a1 : v.a0;
      m_wd   = (w == 1) ? v.d1 : v.d0;
      m_ws   = (w == 1);
      m_we   = (m_wa != 5'd0);
      m_prio = 1 - w;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t rv;
  bit          p0, p1;
  logic [4:0]  pa0, pa1;
  logic [31:0] pd0, pd1;

  initial begin
    rst = 1'b1; wb_stall = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
`ifdef WB_FWD_EN
    fwd_raddr_a = 5'd0; fwd_raddr_b = 5'd0;
`endif
    m_prio = 0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_ws = 1'b0;
    @(posedge clk);
    #1;

    //              rst  stl v0  a0     d0            v1  a1      d1            r0  r1  chk we  wa      wd            ws
    tbl.push_back(mk(1, 0, 1, 5'd1,  32'h11,        1, 5'd9,  32'h99,        0, 0, 0, 0, 5'd0,  32'h0,        0));
    tbl.push_back(mk(1, 0, 1, 5'd1,  32'h11,        1, 5'd9,  32'h99,        0, 0, 1, 0, 5'd0,  32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 1, 0, 5'd0,  32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 5'd8,  32'hDEADBEEF,  0, 5'd0,  32'h0,         1, 0, 1, 0, 5'd0,  32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 1, 1, 5'd8,  32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,         1, 5'd0,  32'h1234,      0, 1, 1, 0, 5'd8,  32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 1, 0, 5'd0,  32'h1234,     1));
    tbl.push_back(mk(0, 0, 1, 5'd1,  32'h100,       1, 5'd9,  32'h900,       1, 0, 1, 0, 5'd0,  32'h1234,     1));
    tbl.push_back(mk(0, 0, 1, 5'd2,  32'h200,       1, 5'd9,  32'h900,       0, 1, 1, 1, 5'd1,  32'h100,      0));
    tbl.push_back(mk(0, 0, 1, 5'd2,  32'h200,       1, 5'd10, 32'hA00,       1, 0, 1, 1, 5'd9,  32'h900,      1));
    tbl.push_back(mk(0, 0, 1, 5'd3,  32'h300,       1, 5'd10, 32'hA00,       0, 1, 1, 1, 5'd2,  32'h200,      0));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 1, 1, 5'd10, 32'hA00,      1));
    tbl.push_back(mk(0, 1, 1, 5'd4,  32'h400,       1, 5'd11, 32'hB00,       0, 0, 1, 0, 5'd10, 32'hA00,      1));
    tbl.push_back(mk(0, 1, 1, 5'd4,  32'h400,       1, 5'd11, 32'hB00,       0, 0, 1, 0, 5'd10, 32'hA00,      1));
    tbl.push_back(mk(0, 1, 1, 5'd4,  32'h400,       1, 5'd11, 32'hB00,       0, 0, 1, 0, 5'd10, 32'hA00,      1));
    tbl.push_back(mk(0, 0, 1, 5'd4,  32'h400,       1, 5'd11, 32'hB00,       1, 0, 1, 0, 5'd10, 32'hA00,      1));
    tbl.push_back(mk(0, 0, 1, 5'd5,  32'h500,       0, 5'd11, 32'hB00,       1, 0, 1, 1, 5'd4,  32'h400,      0));
    tbl.push_back(mk(1, 0, 1, 5'd6,  32'h600,       1, 5'd11, 32'hB00,       0, 0, 1, 1, 5'd5,  32'h500,      0));
    tbl.push_back(mk(0, 0, 1, 5'd6,  32'h600,       1, 5'd11, 32'hB00,       1, 0, 1, 0, 5'd0,  32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         0, 0, 1, 1, 5'd6,  32'h600,      0));

    foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

`ifdef WB_FWD_EN
    rv = mk(0, 0, 1, 5'd3, 32'hCAFE, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
    apply(rv, 1'b0, "fwd_xfer");
    fwd_raddr_a = 5'd3;
    fwd_raddr_b = 5'd0;
    #1;
    chk("fwd_hit_a",  {31'd0, fwd_hit_a}, 32'd1);
    chk("fwd_data_a", fwd_data_a,         32'hCAFE);
    chk("fwd_hit_b",  {31'd0, fwd_hit_b}, 32'd0);
    rv = mk(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, 0);
    apply(rv, 1'b0, "fwd_idle");
    fwd_raddr_a = 5'd0;
`endif

    // randomized traffic: each requester holds its pending write until accepted
    p0 = 1'b0; p1 = 1'b0;
    pa0 = 5'd0; pa1 = 5'd0; pd0 = 32'd0; pd1 = 32'd0;
    for (int n = 0; n < 400; n++) begin
      int w;
      if (!p0 && ($urandom_range(1, 0) == 1)) begin
        p0 = 1'b1; pd0 = $urandom;
        pa0 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      end
      if (!p1 && ($urandom_range(1, 0) == 1)) begin
        p1 = 1'b1; pd1 = $urandom;
        pa1 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      end
      rv = mk(($urandom_range(31, 0) == 0), ($urandom_range(3, 0) == 0),
              p0, pa0, pd0, p1, pa1, pd1, 0, 0, 0, 0, 5'd0, 32'h0, 0);
      if (rv.rst || rv.stall) w = -1;
      else if (p0 && p1) w = m_prio;
      else if (p0) w = 0;
      else if (p1) w = 1;
      else w = -1;
      apply(rv, 1'b0, "rand");
      if (w == 0) p0 = 1'b0;
      if (w == 1) p1 = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
